multi_arb: RTL and testbench
============================

Name: multi_arb

Overview:
Round-robin arbiter and sequencer that shares one start/valid multiplier (multi or multi_vl) between NREQ requesters. It latches the winning requester's operands and holds the multiplier's start high until valid. It returns the product and a one-cycle ack to the winner, then forces a start-low gap before the next operation. It sits between the requesters and the multiplier's clock/reset/mlier/mcand/prodt/start/valid ports.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of gnt_id; must satisfy 2**IDW >= NREQ
W, 32, operand width; product width is 2*W
TIMEOUT, 64, max cycles in BUSY before abort (used only with MULTI_ARB_TIMEOUT_EN)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
req  in  NREQ  per-requester request; held high until ack sampled high
req_mlier  in  NREQ*W  flattened multipliers; requester i at [i*W +: W]
req_mcand  in  NREQ*W  flattened multiplicands; same slicing
ack  out  NREQ  one-hot, one-cycle pulse to the served requester
rsp_prodt  out  2*W  signed product; valid while ack!=0; held until next ack
gnt_id  out  IDW  index of requester being or last served
busy  out  1  high whenever state != IDLE
m_start  out  1  multiplier start; held high for the whole operation
m_mlier  out  W  latched multiplier to the multiplier
m_mcand  out  W  latched multiplicand to the multiplier
m_prodt  in  2*W  multiplier product
m_valid  in  1  multiplier done strobe
err  out  1  timeout flag; port exists only when MULTI_ARB_TIMEOUT_EN is defined

Behaviour:
- Reset (synchronous, at the sampled edge): ack=0, rsp_prodt=0, gnt_id=0, busy=0, m_start=0, m_mlier=0, m_mcand=0, err=0, rr_ptr=0, state=IDLE. Reset mid-operation drops m_start the next cycle. The multiplier shares the same reset.
- All outputs are registered. States: IDLE, BUSY, GAP.
- IDLE: if req!=0, the winner is the first set bit searching rr_ptr, rr_ptr+1, ... wrapping mod NREQ. At that edge: latch req_mlier/req_mcand slices into m_mlier/m_mcand, set gnt_id to the winner, set m_start=1, go to BUSY. If req==0, stay in IDLE.
- BUSY: m_start=1 and operands stable. Later changes on req_* have no effect. While m_valid=0, stay in BUSY.
- BUSY with m_valid=1 at an edge: rsp_prodt<=m_prodt, ack<=onehot(gnt_id), m_start<=0, rr_ptr<=(gnt_id+1) mod NREQ, go to GAP.
- GAP: exactly one cycle. m_start=0 (multiplier restart requirement). ack is high this cycle. Next state is IDLE with ack cleared. No arbitration occurs in GAP.
- A requester must drop req on the edge where it samples ack high. Re-asserting in the next cycle is allowed; that requester then has lowest priority.
- m_valid is ignored in IDLE and GAP.
- If the served requester drops req during BUSY, the operation still completes and ack still pulses.
- Per-operation overhead is multiplier latency + 2 cycles (GAP + IDLE arbitration). The IDLE-to-m_start cycle is included in the latency the multiplier observes.
- No arithmetic is done here. rsp_prodt is the multiplier's 2*W two's-complement result, passed through bit-exact.

Optional Feature:
MULTI_ARB_TIMEOUT_EN
- Defined: the err port exists. A counter clears on entry to BUSY and increments each BUSY cycle. When it reaches TIMEOUT with m_valid still 0: rsp_prodt<=0, ack<=onehot(gnt_id), err<=1 (one-cycle pulse concurrent with ack), m_start<=0, rr_ptr advances, go to GAP. If m_valid and the timeout hit coincide, m_valid wins and err=0.
- Not defined: no counter and no err port. BUSY waits indefinitely for m_valid.

Test Plan:
1. Single request: req=4'b0001, mlier=32'h00000004, mcand=32'h000fffff -> m_start high until m_valid; ack=4'b0001 for exactly one cycle; rsp_prodt=64'h00000000003ffffc; m_start low for at least 1 cycle afterwards.
2. Signed: req[1], mlier=32'hbffffffe, mcand=32'h7aaaaaaa -> ack[1] pulse; rsp_prodt=64'he15555548aaaaaac; gnt_id=1.
3. Contention: req=4'b1111 from reset, distinct operands -> served in order 0,1,2,3; one ack each; each rsp_prodt matches its own operands; m_start=0 between each pair of operations.
4. Fairness: req0 re-asserted immediately after every ack, req2 held high -> order 0,2,0,2...; requester 0 is never served twice in a row while req2 is pending.
5. Operand stability and reset: change req_mlier[0] mid-BUSY -> m_mlier unchanged and result matches the latched operands. Then assert reset for 1 cycle mid-BUSY -> next cycle m_start=0, busy=0, ack=0, gnt_id=0. A re-issued request is served normally.
6. Timeout (macro defined, TIMEOUT=64, stub multiplier never raises m_valid) -> ack and err pulse together after 64 BUSY cycles with rsp_prodt=0, then the next requester is served. Macro undefined: busy stays 1 indefinitely.

Source files
------------

// File: rtl/multi_arb.sv
// multi_arb: round-robin arbiter/sequencer that shares one start/valid multiplier between NREQ
// requesters. The winner's operands are latched and m_start is held high until m_valid. The
// product is then returned with a one-cycle ack, followed by a forced start-low gap cycle.
//
// Optional build macro MULTI_ARB_TIMEOUT_EN: adds the err port and a BUSY-cycle watchdog that
// aborts an operation after TIMEOUT cycles without m_valid.
module multi_arb #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_mlier,
  input  logic [NREQ*W-1:0] req_mcand,
  output logic [NREQ-1:0]   ack,
  output logic [2*W-1:0]    rsp_prodt,
  output logic [IDW-1:0]    gnt_id,
  output logic              busy,
  output logic              m_start,
  output logic [W-1:0]      m_mlier,
  output logic [W-1:0]      m_mcand,
  input  logic [2*W-1:0]    m_prodt,
  input  logic              m_valid
`ifdef MULTI_ARB_TIMEOUT_EN
  ,
  output logic              err
`endif
);

  // Reject configurations the gnt_id width cannot represent.
  if (NREQ < 2 || NREQ > 8 || (2 ** IDW) < NREQ || TIMEOUT < 1) begin : g_bad_cfg
    $error("multi_arb: illegal parameter combination");
  end

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d;

  logic [NREQ-1:0] ack_d;
  logic [2*W-1:0]  rsp_d;
  logic [IDW-1:0]  gnt_d;
  logic            busy_d;
  logic            start_d;
  logic [W-1:0]    mlier_d;
  logic [W-1:0]    mcand_d;

  logic            win_found;
  logic [IDW-1:0]  win_id;
  logic [W-1:0]    win_mlier;
  logic [W-1:0]    win_mcand;
  logic [NREQ-1:0] gnt_onehot;
  logic [IDW-1:0]  rr_next;

`ifdef MULTI_ARB_TIMEOUT_EN
  localparam int unsigned TCW = $clog2(TIMEOUT + 1);
  logic [TCW-1:0] tmo_q, tmo_d;
  logic           err_d;
  logic           tmo_hit;
  assign tmo_hit = (tmo_q == TCW'(TIMEOUT - 1));
`endif

  // Round-robin search: first request at or above rr_q, otherwise wrap to the lowest request.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!win_found && req[j] && (IDW'(j) >= rr_q)) begin
        win_found = 1'b1;
        win_id    = IDW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!win_found && req[j]) begin
        win_found = 1'b1;
        win_id    = IDW'(j);
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    win_mlier = '0;
    win_mcand = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (IDW'(j) == win_id) begin
        win_mlier = req_mlier[j*W +: W];
        win_mcand = req_mcand[j*W +: W];
      end
    end
  end

  // One-hot ack pattern and the pointer value that follows the current grant.
  always_comb begin
    gnt_onehot = '0;
    for (int j = 0; j < NREQ; j++) begin
      gnt_onehot[j] = (IDW'(j) == gnt_id);
    end
    if (gnt_id == IDW'(NREQ - 1)) begin
      rr_next = '0;
    end else begin
      rr_next = gnt_id + 1'b1;
    end
  end

  // Sequencer next-state: IDLE arbitrates, BUSY waits for the multiplier, GAP forces start low.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    ack_d   = ack;
    rsp_d   = rsp_prodt;
    gnt_d   = gnt_id;
    start_d = m_start;
    mlier_d = m_mlier;
    mcand_d = m_mcand;
`ifdef MULTI_ARB_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        ack_d = '0;
        if (win_found) begin
          mlier_d = win_mlier;
          mcand_d = win_mcand;
          gnt_d   = win_id;
          start_d = 1'b1;
          state_d = StBusy;
`ifdef MULTI_ARB_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      StBusy: begin
`ifdef MULTI_ARB_TIMEOUT_EN
        tmo_d = tmo_q + 1'b1;
`endif
        // m_valid takes priority over a coincident timeout.
        if (m_valid) begin
          rsp_d   = m_prodt;
          ack_d   = gnt_onehot;
          start_d = 1'b0;
          rr_d    = rr_next;
          state_d = StGap;
`ifdef MULTI_ARB_TIMEOUT_EN
        end else if (tmo_hit) begin
          rsp_d   = '0;
          ack_d   = gnt_onehot;
          err_d   = 1'b1;
          start_d = 1'b0;
          rr_d    = rr_next;
          state_d = StGap;
`endif
        end
      end
      StGap: begin
        ack_d   = '0;
        start_d = 1'b0;
        state_d = StIdle;
      end
      default: begin
        ack_d   = '0;
        start_d = 1'b0;
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  // Register all state and outputs; reset is synchronous.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      rr_q      <= '0;
      ack       <= '0;
      rsp_prodt <= '0;
      gnt_id    <= '0;
      busy      <= 1'b0;
      m_start   <= 1'b0;
      m_mlier   <= '0;
      m_mcand   <= '0;
`ifdef MULTI_ARB_TIMEOUT_EN
      tmo_q     <= '0;
      err       <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      ack       <= ack_d;
      rsp_prodt <= rsp_d;
      gnt_id    <= gnt_d;
      busy      <= busy_d;
      m_start   <= start_d;
      m_mlier   <= mlier_d;
      m_mcand   <= mcand_d;
`ifdef MULTI_ARB_TIMEOUT_EN
      tmo_q     <= tmo_d;
      err       <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_multi_arb.sv
// Self-checking bench for multi_arb: directed requester stimulus, a behavioural multiplier with
// programmable latency, and a scoreboard monitor that checks every ack against a queue of
// hand-computed expected responses.
module tb_multi_arb;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int W       = 32;
  localparam int TIMEOUT = 64;
  localparam int MAXOP   = 8;

  logic              clock;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_mlier;
  logic [NREQ*W-1:0] req_mcand;
  logic [NREQ-1:0]   ack;
  logic [2*W-1:0]    rsp_prodt;
  logic [IDW-1:0]    gnt_id;
  logic              busy;
  logic              m_start;
  logic [W-1:0]      m_mlier;
  logic [W-1:0]      m_mcand;
  logic [2*W-1:0]    m_prodt = '0;
  logic              m_valid = 1'b0;
`ifdef MULTI_ARB_TIMEOUT_EN
  logic              err;
`endif

  multi_arb #(
    .NREQ   (NREQ),
    .IDW    (IDW),
    .W      (W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .req_mlier(req_mlier),
    .req_mcand(req_mcand),
    .ack      (ack),
    .rsp_prodt(rsp_prodt),
    .gnt_id   (gnt_id),
    .busy     (busy),
    .m_start  (m_start),
    .m_mlier  (m_mlier),
    .m_mcand  (m_mcand),
    .m_prodt  (m_prodt),
    .m_valid  (m_valid)
`ifdef MULTI_ARB_TIMEOUT_EN
    ,
    .err      (err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Counters for the summary line.
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  // Behavioural multiplier: valid pulses mul_lat edges after start rises, needs start low to rearm.
  int   mul_lat  = 1;
  bit   mul_hang = 1'b0;
  int   mcnt     = 0;
  logic mdone    = 1'b0;

  always @(posedge clock) begin
    if (reset || !m_start) begin
      mcnt    <= 0;
      mdone   <= 1'b0;
      m_valid <= 1'b0;
    end else if (mdone || mul_hang) begin
      m_valid <= 1'b0;
    end else if (mcnt == mul_lat - 1) begin
      m_valid <= 1'b1;
      m_prodt <= 64'($signed(m_mlier)) * 64'($signed(m_mcand));
      mdone   <= 1'b1;
    end else begin
      mcnt <= mcnt + 1;
    end
  end

  // Scoreboard of expected responses in service order.
  typedef struct {
    int          id;
    logic [63:0] p;
    bit          e;
  } exp_t;
  exp_t exp_q[$];

  // Requester operation tables, consumed by the agent step inside tick().
  logic [W-1:0] op_ml[NREQ][MAXOP];
  logic [W-1:0] op_mc[NREQ][MAXOP];
  int           op_n[NREQ];
  int           op_idx[NREQ];

  task automatic add_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
    op_ml[r][op_n[r]] = a;
    op_mc[r][op_n[r]] = b;
    op_n[r]++;
  endtask

  task automatic expect_rsp(input int r, input logic [63:0] p, input bit e);
    exp_t x;
    x.id = r;
    x.p  = p;
    x.e  = e;
    exp_q.push_back(x);
  endtask

  // Advance to the next falling edge, then let each requester drop on ack or raise its next op.
  task automatic tick();
    @(negedge clock);
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && ack[i]) begin
        req[i] = 1'b0;
        op_idx[i]++;
      end else if (!req[i] && op_idx[i] < op_n[i]) begin
        req_mlier[i*W +: W] = op_ml[i][op_idx[i]];
        req_mcand[i*W +: W] = op_mc[i][op_idx[i]];
        req[i] = 1'b1;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    req   = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_n[i]   = 0;
      op_idx[i] = 0;
    end
    exp_q.delete();
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int b = budget;
    while (exp_q.size() != 0 && b > 0) begin
      tick();
      b--;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_start(input int budget);
    int b = budget;
    while (!m_start && b > 0) begin
      tick();
      b--;
    end
    chk("start_seen", 64'(m_start), 64'd1);
  endtask

  // Monitor: compares every ack against the scoreboard, checks ack width, gap and BUSY length.
  int              busy_run = 0;
  logic [NREQ-1:0] prev_ack = '0;

  initial begin
    forever begin
      @(negedge clock);
      if (prev_ack != '0) chk("ack_one_cycle", 64'(ack), 64'd0);
      if (ack != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 64'(ack), 64'd0);
        end else begin
          exp_t            x;
          logic [NREQ-1:0] oh;
          x  = exp_q.pop_front();
          oh = '0;
          oh[x.id] = 1'b1;
          chk("ack_onehot", 64'(ack), 64'(oh));
          chk("gnt_id", 64'(gnt_id), 64'(x.id));
          chk("rsp_prodt", rsp_prodt, x.p);
          chk("gap_start_low", 64'(m_start), 64'd0);
`ifdef MULTI_ARB_TIMEOUT_EN
          chk("err", 64'(err), 64'(x.e));
          chk("busy_cycles", 64'(busy_run), x.e ? 64'(TIMEOUT) : 64'(mul_lat + 1));
`else
          chk("busy_cycles", 64'(busy_run), 64'(mul_lat + 1));
`endif
        end
        busy_run = 0;
      end else if (m_start) begin
        busy_run++;
      end else begin
        busy_run = 0;
      end
      prev_ack = ack;
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    req       = '0;
    req_mlier = '0;
    req_mcand = '0;
    do_reset(3);

    // Reset state.
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_start", 64'(m_start), 64'd0);
    chk("rst_gnt", 64'(gnt_id), 64'd0);
    chk("rst_rsp", rsp_prodt, 64'd0);
    chk("rst_mlier", 64'(m_mlier), 64'd0);

    // 1: single request.
    add_op(0, 32'h0000_0004, 32'h000f_ffff);
    expect_rsp(0, 64'h0000_0000_003f_fffc, 1'b0);
    wait_drain(50);
    tick();
    chk("t1_start_low_after", 64'(m_start), 64'd0);

    // 2: signed operands on requester 1.
    add_op(1, 32'hbfff_fffe, 32'h7aaa_aaaa);
    expect_rsp(1, 64'he155_5554_8aaa_aaac, 1'b0);
    wait_drain(50);

    // 3: all four contend from reset; served 0,1,2,3.
    do_reset(2);
    add_op(0, 32'd3, 32'd5);
    add_op(1, 32'hffff_fffe, 32'd7);
    add_op(2, 32'd100, 32'd100);
    add_op(3, 32'hffff_ffff, 32'hffff_ffff);
    expect_rsp(0, 64'h0000_0000_0000_000f, 1'b0);
    expect_rsp(1, 64'hffff_ffff_ffff_fff2, 1'b0);
    expect_rsp(2, 64'h0000_0000_0000_2710, 1'b0);
    expect_rsp(3, 64'h0000_0000_0000_0001, 1'b0);
    wait_drain(100);

    // 4: fairness, requester 0 re-asserts after each ack while 2 stays pending.
    do_reset(2);
    add_op(0, 32'd2, 32'd3);
    add_op(0, 32'd5, 32'd5);
    add_op(0, 32'd7, 32'hffff_ffff);
    add_op(2, 32'h10, 32'h10);
    add_op(2, 32'h1000, 32'h1000);
    add_op(2, 32'h8000_0000, 32'd2);
    expect_rsp(0, 64'h0000_0000_0000_0006, 1'b0);
    expect_rsp(2, 64'h0000_0000_0000_0100, 1'b0);
    expect_rsp(0, 64'h0000_0000_0000_0019, 1'b0);
    expect_rsp(2, 64'h0000_0000_0100_0000, 1'b0);
    expect_rsp(0, 64'hffff_ffff_ffff_fff9, 1'b0);
    expect_rsp(2, 64'hffff_ffff_0000_0000, 1'b0);
    wait_drain(150);

    // 5: operand stability mid-BUSY, then reset mid-BUSY and re-issue.
    do_reset(2);
    mul_lat = 6;
    add_op(0, 32'd9, 32'd11);
    expect_rsp(0, 64'h0000_0000_0000_0063, 1'b0);
    wait_start(20);
    tick();
    req_mlier[0 +: W] = 32'h0000_1234;
    tick();
    chk("t5_mlier_stable", 64'(m_mlier), 64'd9);
    wait_drain(50);

    add_op(1, 32'd3, 32'd3);
    wait_start(20);
    tick();
    chk("t5_gnt_before_rst", 64'(gnt_id), 64'd1);
    do_reset(1);
    chk("t5_rst_start", 64'(m_start), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_ack", 64'(ack), 64'd0);
    chk("t5_rst_gnt", 64'(gnt_id), 64'd0);
    add_op(1, 32'd3, 32'd3);
    expect_rsp(1, 64'h0000_0000_0000_0009, 1'b0);
    wait_drain(50);

    // 6: multiplier that never completes.
    do_reset(2);
`ifdef MULTI_ARB_TIMEOUT_EN
    mul_hang = 1'b1;
    add_op(1, 32'd5, 32'd5);
    add_op(2, 32'd6, 32'd7);
    expect_rsp(1, 64'd0, 1'b1);
    expect_rsp(2, 64'h0000_0000_0000_002a, 1'b0);
    begin
      int b = 300;
      while (exp_q.size() > 1 && b > 0) begin
        tick();
        b--;
      end
    end
    mul_hang = 1'b0;
    wait_drain(300);
`else
    mul_hang = 1'b1;
    add_op(0, 32'd5, 32'd5);
    repeat (150) tick();
    chk("t6_busy_held", 64'(busy), 64'd1);
    chk("t6_start_held", 64'(m_start), 64'd1);
    chk("t6_no_ack", 64'(ack), 64'd0);
    mul_hang = 1'b0;
    do_reset(2);
`endif

    repeat (10) tick();
    chk("final_idle", 64'(busy), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
